// File: rtl/window_loader_pkg.sv
// Shared constants and FSM state encoding for the window loader.
package window_loader_pkg;

  localparam int DATA_WIDTH_DEF      = 8;
  localparam int BRAM_ADDR_WIDTH_DEF = 10;
  localparam int ADDR_SIZE_DEF       = 4;
  localparam int IMG_W_DEF           = 28;
  localparam int K_DEF               = 3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_WAIT_ACK,
    ST_ADVANCE,
    ST_DONE
  } state_t;

  // Number of valid output positions along one image axis.
  function automatic int n_out(input int img_w, input int k);
    return img_w - k + 1;
  endfunction

endpackage

// File: rtl/window_loader_patch_addr_gen.sv
// Walks a K x (K+1) image patch row-major, producing BRAM addresses
// incrementally (no multiplier) together with the patch indices.
module window_loader_patch_addr_gen #(
  parameter int IMG_W           = 28,
  parameter int K               = 3,
  parameter int BRAM_ADDR_WIDTH = 10,
  parameter int PW              = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_load,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_base,
  output logic [BRAM_ADDR_WIDTH-1:0] o_addr,
  output logic                       o_rd_en,
  output logic [PW-1:0]              o_pr,
  output logic [PW-1:0]              o_pc,
  output logic                       o_last
);

  logic [BRAM_ADDR_WIDTH-1:0] r_addr;
  logic [PW-1:0]              r_pr;
  logic [PW-1:0]              r_pc;
  logic                       r_active;
  logic                       w_last;

  assign w_last  = r_active && (r_pr == PW'(K - 1)) && (r_pc == PW'(K));
  assign o_addr  = r_addr;
  assign o_rd_en = r_active;
  assign o_pr    = r_pr;
  assign o_pc    = r_pc;
  assign o_last  = w_last;

  // Step through the patch; the address is held after the last read.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_addr   <= '0;
      r_pr     <= '0;
      r_pc     <= '0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_addr   <= i_base;
      r_pr     <= '0;
      r_pc     <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      if (w_last) begin
        r_active <= 1'b0;
      end else if (r_pc == PW'(K)) begin
        r_pc   <= '0;
        r_pr   <= r_pr + PW'(1);
        r_addr <= r_addr + BRAM_ADDR_WIDTH'(IMG_W - K);
      end else begin
        r_pc   <= r_pc + PW'(1);
        r_addr <= r_addr + BRAM_ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: rtl/window_loader.sv
// Fills two horizontally adjacent KxK window registers from the image
// BRAM, hands each pair to the convolution engine and slides over the map.
module window_loader
  import window_loader_pkg::*;
#(
  parameter int IMG_W           = IMG_W_DEF,
  parameter int K               = K_DEF,
  parameter int DATA_WIDTH      = DATA_WIDTH_DEF,
  parameter int BRAM_ADDR_WIDTH = BRAM_ADDR_WIDTH_DEF,
  parameter int ADDR_SIZE       = ADDR_SIZE_DEF
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_start,
  input  logic [BRAM_ADDR_WIDTH-1:0] i_img_base_addr,
  output logic [BRAM_ADDR_WIDTH-1:0] o_bram_rd_addr,
  input  logic [DATA_WIDTH-1:0]      i_bram_rd_data,
  output logic                       o_win1_wr_en,
  output logic [ADDR_SIZE-1:0]       o_win1_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_win1_wr_data,
  output logic                       o_win2_wr_en,
  output logic [ADDR_SIZE-1:0]       o_win2_wr_addr,
  output logic [DATA_WIDTH-1:0]      o_win2_wr_data,
  output logic                       o_window_valid,
  output logic                       o_win2_valid,
  input  logic                       i_window_ack,
  output logic [4:0]                 o_out_row,
  output logic [4:0]                 o_out_col,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int N_OUT = n_out(IMG_W, K);
  localparam int PW    = $clog2(K + 1);

  state_t                     r_state;
  logic [4:0]                 r_row, r_col;
  logic [BRAM_ADDR_WIDTH-1:0] r_win_addr;
  logic                       r_valid, r_win2_valid, r_busy, r_done;
  logic                       r_wr1_en, r_wr2_en, r_last_d;
  logic [ADDR_SIZE-1:0]       r_wr1_addr, r_wr2_addr;

  logic                       w_load, w_rd_en, w_last;
  logic [BRAM_ADDR_WIDTH-1:0] w_load_addr, w_win_addr_nxt;
  logic [PW-1:0]              w_pr, w_pc;
  logic [4:0]                 w_col_nxt, w_row_nxt;
  logic                       w_wrap, w_pass_end, w_win2_ok;

  assign w_col_nxt  = r_col + 5'd2;
  assign w_row_nxt  = r_row + 5'd1;
  assign w_wrap     = (w_col_nxt >= 5'(N_OUT));
  assign w_pass_end = w_wrap && (w_row_nxt == 5'(N_OUT));
  assign w_win2_ok  = ((r_col + 5'd1) < 5'(N_OUT));

  // Top-left pixel of the next pair, tracked incrementally.
  assign w_win_addr_nxt = w_wrap
      ? (r_win_addr - BRAM_ADDR_WIDTH'(r_col) + BRAM_ADDR_WIDTH'(IMG_W))
      : (r_win_addr + BRAM_ADDR_WIDTH'(2));

  assign w_load = ((r_state == ST_IDLE) && i_start) ||
                  ((r_state == ST_ADVANCE) && !w_pass_end);
  assign w_load_addr = (r_state == ST_IDLE) ? i_img_base_addr : w_win_addr_nxt;

  window_loader_patch_addr_gen #(
    .IMG_W           (IMG_W),
    .K               (K),
    .BRAM_ADDR_WIDTH (BRAM_ADDR_WIDTH),
    .PW              (PW)
  ) u_addr_gen (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_load  (w_load),
    .i_base  (w_load_addr),
    .o_addr  (o_bram_rd_addr),
    .o_rd_en (w_rd_en),
    .o_pr    (w_pr),
    .o_pc    (w_pc),
    .o_last  (w_last)
  );

  // Delay patch indices by the BRAM latency and steer each pixel to one or both windows.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_wr1_en   <= 1'b0;
      r_wr2_en   <= 1'b0;
      r_wr1_addr <= '0;
      r_wr2_addr <= '0;
      r_last_d   <= 1'b0;
    end else begin
      r_wr1_en   <= w_rd_en && (w_pc < PW'(K));
      r_wr2_en   <= w_rd_en && (w_pc != '0) && w_win2_ok;
      r_wr1_addr <= ADDR_SIZE'(int'(w_pr) * K + int'(w_pc));
      r_wr2_addr <= ADDR_SIZE'(int'(w_pr) * K + int'(w_pc) - 1);
      r_last_d   <= w_last;
    end
  end

  // Pass sequencing with registered handshake and status outputs.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_state      <= ST_IDLE;
      r_row        <= '0;
      r_col        <= '0;
      r_win_addr   <= '0;
      r_valid      <= 1'b0;
      r_win2_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            r_win_addr <= i_img_base_addr;
            r_row      <= '0;
            r_col      <= '0;
            r_busy     <= 1'b1;
            r_state    <= ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (r_last_d) begin
            r_valid      <= 1'b1;
            r_win2_valid <= w_win2_ok;
            r_state      <= ST_WAIT_ACK;
          end
        end
        ST_WAIT_ACK: begin
          if (i_window_ack) begin
            r_valid      <= 1'b0;
            r_win2_valid <= 1'b0;
            r_state      <= ST_ADVANCE;
          end
        end
        ST_ADVANCE: begin
          r_win_addr <= w_win_addr_nxt;
          r_col      <= w_wrap ? 5'd0 : w_col_nxt;
          if (w_wrap) r_row <= w_row_nxt;
          if (w_pass_end) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_state <= ST_FETCH;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_win1_wr_en   = r_wr1_en;
  assign o_win1_wr_addr = r_wr1_addr;
  assign o_win1_wr_data = r_wr1_en ? i_bram_rd_data : '0;
  assign o_win2_wr_en   = r_wr2_en;
  assign o_win2_wr_addr = r_wr2_addr;
  assign o_win2_wr_data = r_wr2_en ? i_bram_rd_data : '0;
  assign o_window_valid = r_valid;
  assign o_win2_valid   = r_win2_valid;
  assign o_out_row      = r_row;
  assign o_out_col      = r_col;
  assign o_busy         = r_busy;
  assign o_done         = r_done;

endmodule

// File: tb/tb_window_loader.sv
// Directed bench: a 28x28 instance (a_*) and a 5x5 instance (b_*) share clock and reset.
module tb_window_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  int         n_vec = 0;
  int         n_err = 0;

  logic       a_start = 1'b0, a_ack = 1'b0;
  logic [9:0] a_base = '0, a_addr;
  logic [7:0] a_rdata, a_w1_data, a_w2_data;
  logic       a_w1_en, a_w2_en, a_valid, a_w2v, a_busy, a_done;
  logic [3:0] a_w1_addr, a_w2_addr;
  logic [4:0] a_row, a_col;

  logic       b_start = 1'b0, b_ack = 1'b0;
  logic [9:0] b_base = '0, b_addr;
  logic [7:0] b_rdata, b_w1_data, b_w2_data;
  logic       b_w1_en, b_w2_en, b_valid, b_w2v, b_busy, b_done;
  logic [3:0] b_w1_addr, b_w2_addr;
  logic [4:0] b_row, b_col;

  window_loader #(.IMG_W(28), .K(3)) dut_a (
    .i_clk(clk), .i_rst(rst_n), .i_start(a_start), .i_img_base_addr(a_base),
    .o_bram_rd_addr(a_addr), .i_bram_rd_data(a_rdata),
    .o_win1_wr_en(a_w1_en), .o_win1_wr_addr(a_w1_addr), .o_win1_wr_data(a_w1_data),
    .o_win2_wr_en(a_w2_en), .o_win2_wr_addr(a_w2_addr), .o_win2_wr_data(a_w2_data),
    .o_window_valid(a_valid), .o_win2_valid(a_w2v), .i_window_ack(a_ack),
    .o_out_row(a_row), .o_out_col(a_col), .o_busy(a_busy), .o_done(a_done));

  window_loader #(.IMG_W(5), .K(3)) dut_b (
    .i_clk(clk), .i_rst(rst_n), .i_start(b_start), .i_img_base_addr(b_base),
    .o_bram_rd_addr(b_addr), .i_bram_rd_data(b_rdata),
    .o_win1_wr_en(b_w1_en), .o_win1_wr_addr(b_w1_addr), .o_win1_wr_data(b_w1_data),
    .o_win2_wr_en(b_w2_en), .o_win2_wr_addr(b_w2_addr), .o_win2_wr_data(b_w2_data),
    .o_window_valid(b_valid), .o_win2_valid(b_w2v), .i_window_ack(b_ack),
    .o_out_row(b_row), .o_out_col(b_col), .o_busy(b_busy), .o_done(b_done));

  // Image BRAMs: pixel value = low address byte, one cycle read latency.
  always @(posedge clk) begin
    a_rdata <= a_addr[7:0];
    b_rdata <= b_addr[7:0];
  end

  logic [7:0] a_win1 [16];
  logic [7:0] a_win2 [16];
  logic [7:0] b_win1 [16];
  logic [7:0] b_win2 [16];
  int a_n1 = 0, a_n2 = 0, b_n1 = 0, b_n2 = 0, a_dcnt = 0, b_dcnt = 0;

  // Model of the two window registers plus write and done counters.
  always @(negedge clk) begin
    if (a_w1_en) begin a_win1[a_w1_addr] = a_w1_data; a_n1++; end
    if (a_w2_en) begin a_win2[a_w2_addr] = a_w2_data; a_n2++; end
    if (b_w1_en) begin b_win1[b_w1_addr] = b_w1_data; b_n1++; end
    if (b_w2_en) begin b_win2[b_w2_addr] = b_w2_data; b_n2++; end
    if (a_done) a_dcnt++;
    if (b_done) b_dcnt++;
  end

  logic [7:0] e1_0   [9] = '{8'd0, 8'd1, 8'd2, 8'd28, 8'd29, 8'd30, 8'd56, 8'd57, 8'd58};
  logic [7:0] e2_0   [9] = '{8'd1, 8'd2, 8'd3, 8'd29, 8'd30, 8'd31, 8'd57, 8'd58, 8'd59};
  logic [7:0] e1_100 [9] = '{8'd100, 8'd101, 8'd102, 8'd128, 8'd129, 8'd130, 8'd156, 8'd157, 8'd158};

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; a_start = 1'b0; a_ack = 1'b0; b_start = 1'b0; b_ack = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_a(input logic [9:0] base, output int lat);
    @(negedge clk);
    a_base = base; a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    lat = 1;
    while (!a_valid && lat < 100) begin @(negedge clk); lat++; end
  endtask

  task automatic ack_a();
    @(negedge clk); a_ack = 1'b1;
    @(negedge clk); a_ack = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_addr, a_w1_en, a_w2_en, a_w1_addr, a_w2_addr, a_w1_data, a_w2_data,
         a_valid, a_w2v, a_row, a_col, a_busy, a_done} !== 50'd0) begin
      n_err++; $display("FAIL reset_a: outputs not all zero (addr=%0d busy=%0b valid=%0b)", a_addr, a_busy, a_valid);
    end
    n_vec++;
    if ({b_addr, b_w1_en, b_w2_en, b_valid, b_w2v, b_row, b_col, b_busy, b_done} !== 26'd0) begin
      n_err++; $display("FAIL reset_b: outputs not all zero (addr=%0d busy=%0b)", b_addr, b_busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_first_pair();
    int lat, n1b, n2b;
    do_reset();
    n1b = a_n1; n2b = a_n2;
    start_a(10'd0, lat);
    n_vec++;
    if (lat !== 14) begin n_err++; $display("FAIL first_latency: got %0d want 14", lat); end
    n_vec++;
    if ({a_w2v, a_row, a_col, a_busy} !== {1'b1, 5'd0, 5'd0, 1'b1}) begin
      n_err++; $display("FAIL first_status: w2v=%0b row=%0d col=%0d busy=%0b want 1/0/0/1", a_w2v, a_row, a_col, a_busy);
    end
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (a_win1[i] !== e1_0[i]) begin n_err++; $display("FAIL first_win1[%0d]: got %0d want %0d", i, a_win1[i], e1_0[i]); end
      n_vec++;
      if (a_win2[i] !== e2_0[i]) begin n_err++; $display("FAIL first_win2[%0d]: got %0d want %0d", i, a_win2[i], e2_0[i]); end
    end
    n_vec++;
    if ((a_n1 - n1b) !== 9 || (a_n2 - n2b) !== 9) begin
      n_err++; $display("FAIL first_writes: win1=%0d win2=%0d want 9/9", a_n1 - n1b, a_n2 - n2b);
    end
  endtask

  task automatic test_ack_delay();
    int lat, n1b, n2b;
    do_reset();
    start_a(10'd0, lat);
    n1b = a_n1; n2b = a_n2;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      n_vec++;
      if ({a_addr, a_valid, a_w2v, a_row, a_col, a_busy} !== {10'd59, 1'b1, 1'b1, 5'd0, 5'd0, 1'b1}) begin
        n_err++; $display("FAIL hold_state[%0d]: addr=%0d valid=%0b row=%0d col=%0d want 59/1/0/0", i, a_addr, a_valid, a_row, a_col);
      end
    end
    n_vec++;
    if ((a_n1 - n1b) !== 0 || (a_n2 - n2b) !== 0) begin
      n_err++; $display("FAIL hold_writes: win1=%0d win2=%0d want 0/0", a_n1 - n1b, a_n2 - n2b);
    end
    ack_a();
    n_vec++;
    if (a_valid !== 1'b0) begin n_err++; $display("FAIL hold_release: valid=%0b want 0", a_valid); end
  endtask

  task automatic test_full_pass(input bit interfere);
    int pairs, cyc, er, ec, dbase, lr, lc;
    logic [7:0] px, lpx;
    bit fin;
    do_reset();
    dbase = a_dcnt; pairs = 0; er = 0; ec = 0; fin = 1'b0; lr = -1; lc = -1; lpx = '0;
    @(negedge clk); a_base = 10'd0; a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    while (!fin && pairs < 400) begin
      cyc = 0;
      while (!a_valid && a_dcnt == dbase && cyc < 100) begin @(negedge clk); cyc++; end
      if (a_valid) begin
        px = 8'(er * 28 + ec);
        n_vec++;
        if ({a_row, a_col, a_w2v} !== {5'(er), 5'(ec), 1'b1}) begin
          n_err++; $display("FAIL pass_coord: got r%0d c%0d w2v=%0b want r%0d c%0d w2v=1", a_row, a_col, a_w2v, er, ec);
        end
        n_vec++;
        if ({a_win1[0], a_win1[8], a_win2[0]} !== {px, 8'(px + 8'd58), 8'(px + 8'd1)}) begin
          n_err++; $display("FAIL pass_pixels r%0d c%0d: got %0d/%0d/%0d want %0d/%0d/%0d", er, ec,
                            a_win1[0], a_win1[8], a_win2[0], px, 8'(px + 8'd58), 8'(px + 8'd1));
        end
        lr = int'(a_row); lc = int'(a_col); lpx = a_win1[0];
        pairs++;
        ec += 2;
        if (ec >= 26) begin ec = 0; er++; end
        if (interfere) a_start = 1'b1;
        @(negedge clk); a_start = 1'b0; a_ack = 1'b1;
        @(negedge clk); a_ack = 1'b0;
        if (interfere) begin
          @(negedge clk); @(negedge clk); a_ack = 1'b1;
          @(negedge clk); a_ack = 1'b0;
        end
      end else if (a_dcnt != dbase) begin
        fin = 1'b1;
      end else begin
        n_vec++; n_err++;
        $display("FAIL pass_timeout: no valid or done after pair %0d", pairs);
        fin = 1'b1;
      end
    end
    repeat (3) @(negedge clk);
    n_vec++;
    if (pairs !== 338) begin n_err++; $display("FAIL pass_count: got %0d want 338", pairs); end
    n_vec++;
    if ({lr, lc} !== {32'd25, 32'd24} || lpx !== 8'hD4) begin
      n_err++; $display("FAIL pass_last: got r%0d c%0d px=%0h want r25 c24 px=d4", lr, lc, lpx);
    end
    n_vec++;
    if ((a_dcnt - dbase) !== 1) begin n_err++; $display("FAIL pass_done: pulses=%0d want 1", a_dcnt - dbase); end
    n_vec++;
    if ({a_busy, a_valid, a_done} !== 3'b000) begin
      n_err++; $display("FAIL pass_idle: busy=%0b valid=%0b done=%0b want 0/0/0", a_busy, a_valid, a_done);
    end
  endtask

  task automatic test_small_image();
    int pairs, cyc, er, ec, dbase, n1b, n2b;
    bit fin;
    do_reset();
    dbase = b_dcnt; pairs = 0; er = 0; ec = 0; fin = 1'b0;
    n1b = b_n1; n2b = b_n2;
    @(negedge clk); b_base = 10'd0; b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    while (!fin && pairs < 10) begin
      cyc = 0;
      while (!b_valid && b_dcnt == dbase && cyc < 100) begin @(negedge clk); cyc++; end
      if (b_valid) begin
        n_vec++;
        if ({b_row, b_col, b_w2v} !== {5'(er), 5'(ec), (ec == 0)}) begin
          n_err++; $display("FAIL small_coord: got r%0d c%0d w2v=%0b want r%0d c%0d w2v=%0b", b_row, b_col, b_w2v, er, ec, (ec == 0));
        end
        n_vec++;
        if ((b_n1 - n1b) !== 9 || (b_n2 - n2b) !== ((ec == 0) ? 9 : 0)) begin
          n_err++; $display("FAIL small_writes r%0d c%0d: win1=%0d win2=%0d want 9/%0d", er, ec, b_n1 - n1b, b_n2 - n2b, (ec == 0) ? 9 : 0);
        end
        n_vec++;
        if (b_win1[0] !== 8'(er * 5 + ec)) begin
          n_err++; $display("FAIL small_pixel r%0d c%0d: got %0d want %0d", er, ec, b_win1[0], er * 5 + ec);
        end
        n1b = b_n1; n2b = b_n2;
        pairs++;
        ec += 2;
        if (ec >= 3) begin ec = 0; er++; end
        @(negedge clk); b_ack = 1'b1;
        @(negedge clk); b_ack = 1'b0;
      end else if (b_dcnt != dbase) begin
        fin = 1'b1;
      end else begin
        n_vec++; n_err++;
        $display("FAIL small_timeout: no valid or done after pair %0d", pairs);
        fin = 1'b1;
      end
    end
    repeat (2) @(negedge clk);
    n_vec++;
    if (pairs !== 6 || (b_dcnt - dbase) !== 1) begin
      n_err++; $display("FAIL small_count: pairs=%0d done=%0d want 6/1", pairs, b_dcnt - dbase);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    do_reset();
    start_a(10'd0, lat);
    for (int k = 1; k <= 4; k++) begin
      ack_a();
      if (k < 4) begin
        lat = 0;
        while (!a_valid && lat < 100) begin @(negedge clk); lat++; end
      end
    end
    repeat (6) @(negedge clk);
    n_vec++;
    if ({a_busy, a_valid, a_row, a_col} !== {1'b1, 1'b0, 5'd0, 5'd8}) begin
      n_err++; $display("FAIL mid_prefetch: busy=%0b valid=%0b r%0d c%0d want 1/0 r0 c8", a_busy, a_valid, a_row, a_col);
    end
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({a_addr, a_w1_en, a_w2_en, a_w1_addr, a_w2_addr, a_w1_data, a_w2_data,
         a_valid, a_w2v, a_row, a_col, a_busy, a_done} !== 50'd0) begin
      n_err++; $display("FAIL mid_reset: outputs not zero (addr=%0d w1=%0b busy=%0b)", a_addr, a_w1_en, a_busy);
    end
    rst_n = 1'b1;
    start_a(10'd100, lat);
    n_vec++;
    if ({lat, a_row, a_col} !== {32'd14, 5'd0, 5'd0}) begin
      n_err++; $display("FAIL restart_status: lat=%0d r%0d c%0d want 14 r0 c0", lat, a_row, a_col);
    end
    for (int i = 0; i < 9; i++) begin
      n_vec++;
      if (a_win1[i] !== e1_100[i]) begin n_err++; $display("FAIL restart_win1[%0d]: got %0d want %0d", i, a_win1[i], e1_100[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_first_pair();
    test_ack_delay();
    test_full_pass(1'b0);
    test_small_image();
    test_reset_mid();
    test_full_pass(1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
